// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic-array tile controller.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } ctrl_state_t;

  // Bit width able to index n items, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/array_tile_controller_if.sv
// Stream, operand-buffer and array control signals of one tile controller.
interface array_tile_controller_if #(
  parameter int unsigned SEL_W = 2
) ();

  logic             s_axis_valid;
  logic             s_axis_last;
  logic             s_axis_ready;
  logic             m_axis_ready;
  logic             m_axis_valid;
  logic             m_axis_last;
  logic             buff_is_full;
  logic             buff_is_empty;
  logic             buff_rst_n;
  logic             buff_wr;
  logic             buff_rd;
  logic             arr_C_valid;
  logic             arr_rst_n;
  logic             arr_en;
  logic [SEL_W-1:0] arr_out_sel;

  // Controller side
  modport master (
    input  s_axis_valid, s_axis_last, m_axis_ready,
           buff_is_full, buff_is_empty, arr_C_valid,
    output s_axis_ready, m_axis_valid, m_axis_last,
           buff_rst_n, buff_wr, buff_rd, arr_rst_n, arr_en, arr_out_sel
  );

  // Stream source/sink, buffer and array side
  modport slave (
    output s_axis_valid, s_axis_last, m_axis_ready,
           buff_is_full, buff_is_empty, arr_C_valid,
    input  s_axis_ready, m_axis_valid, m_axis_last,
           buff_rst_n, buff_wr, buff_rd, arr_rst_n, arr_en, arr_out_sel
  );

endinterface

// File: rtl/array_tile_controller.sv
// Control FSM for one systolic tile pass: fill buffer, feed array, wait for
// the result with a bounded drain, then stream result rows out.
module array_tile_controller
  import systolic_pkg::*;
#(
  parameter int unsigned DIM        = 4,
  parameter int unsigned FILL_DEPTH = 2 * DIM,
  parameter int unsigned OUT_BEATS  = DIM,
  parameter int unsigned DRAIN_CYC  = 3 * DIM - 2,
  parameter int unsigned TILE_W     = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  array_tile_controller_if.master bus,
  input  logic                    i_err_clr,
  output logic                    o_err,
  output logic                    o_busy,
  output logic [TILE_W-1:0]       o_tile_cnt
);

  localparam int unsigned FILL_W  = $clog2(FILL_DEPTH + 1);
  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYC + 1);
  localparam int unsigned OUT_W   = clog2_min1(OUT_BEATS);

  ctrl_state_t        state;
  logic [FILL_W-1:0]  fill_cnt;
  logic [FILL_W-1:0]  fill_inc;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [OUT_W-1:0]   out_cnt;

  logic s_ready_c, wr_c, rd_c, en_c, mvalid_c, mlast_c;
  logic early_c, fill_done_c, timeout_c, out_done_c, err_set_c;

  // Strobes and events decoded from state, counters and handshakes
  always_comb begin
    fill_inc    = fill_cnt + FILL_W'(1);
    s_ready_c   = ((state == IDLE) || (state == FILL)) && !bus.buff_is_full;
    wr_c        = bus.s_axis_valid && s_ready_c;
    rd_c        = (state == FEED) && !bus.buff_is_empty;
    en_c        = (state == FEED) || (state == DRAIN);
    mvalid_c    = (state == OUT);
    mlast_c     = mvalid_c && (out_cnt == OUT_W'(OUT_BEATS - 1));
    out_done_c  = mlast_c && bus.m_axis_ready;
    // Only beats after the first can end a burst early
    early_c     = (state == FILL) && wr_c && bus.s_axis_last &&
                  (fill_inc < FILL_W'(FILL_DEPTH));
    fill_done_c = wr_c && !early_c && (fill_inc == FILL_W'(FILL_DEPTH));
    timeout_c   = (state == DRAIN) && !bus.arr_C_valid &&
                  (drain_cnt == DRAIN_W'(DRAIN_CYC - 1));
    err_set_c   = early_c || (fill_done_c && !bus.s_axis_last) || timeout_c;
  end

  assign bus.s_axis_ready = s_ready_c;
  assign bus.buff_wr      = wr_c;
  assign bus.buff_rd      = rd_c;
  assign bus.arr_en       = en_c;
  assign bus.m_axis_valid = mvalid_c;
  assign bus.m_axis_last  = mlast_c;
  assign bus.arr_out_sel  = mvalid_c ? out_cnt : '0;
  assign bus.buff_rst_n   = !(early_c || timeout_c || out_done_c);
  assign bus.arr_rst_n    = !((state == IDLE) || timeout_c || out_done_c);
  assign o_busy           = (state != IDLE);

  // State, counters and sticky status
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      fill_cnt   <= '0;
      drain_cnt  <= '0;
      out_cnt    <= '0;
      o_tile_cnt <= '0;
      o_err      <= 1'b0;
    end else begin
      o_err <= err_set_c || (o_err && !i_err_clr);
      case (state)
        IDLE, FILL: begin
          if (early_c) begin
            state    <= IDLE;
            fill_cnt <= '0;
          end else if (fill_done_c) begin
            state    <= FEED;
            fill_cnt <= '0;
          end else if (wr_c) begin
            state    <= FILL;
            fill_cnt <= fill_inc;
          end
        end
        FEED: begin
          if (bus.buff_is_empty) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + DRAIN_W'(1);
          if (bus.arr_C_valid) begin
            state   <= OUT;
            out_cnt <= '0;
          end else if (timeout_c) begin
            state <= IDLE;
          end
        end
        OUT: begin
          if (out_done_c) begin
            state      <= IDLE;
            out_cnt    <= '0;
            o_tile_cnt <= o_tile_cnt + TILE_W'(1);
          end else if (bus.m_axis_ready) begin
            out_cnt <= out_cnt + OUT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/array_tile_controller.md
# array_tile_controller

Parametrised control FSM for one systolic-array tile pass. It accepts a fixed-length input burst over AXI-Stream into the operand buffer, then streams the buffer into the array. It waits for the array result with a bounded drain timeout and emits the result rows over AXI-Stream with `m_axis_last`. Compared with the single-pass controller it adds:
- parametrised burst and output lengths;
- TLAST framing checks;
- row selection on the result mux;
- a sticky error flag and a completed-tile counter.

## Interface
Parameters:
- `DIM`, 4: array dimension.
- `FILL_DEPTH`, 2*DIM: input beats per tile; must equal buffer depth.
- `OUT_BEATS`, DIM: result beats per tile, ≥ 1.
- `DRAIN_CYC`, 3*DIM-2: maximum cycles from buffer-empty to `arr_C_valid`.
- `TILE_W`, 16: width of tile counter.

Ports:
- `i_clk`, in, 1: single clock.
- `i_rst_n`, in, 1: asynchronous reset, active-low.
- `s_axis_valid`, in, 1: input beat valid.
- `s_axis_last`, in, 1: input beat is last of burst.
- `s_axis_ready`, out, 1: controller accepts input beat.
- `m_axis_ready`, in, 1: downstream accepts result beat.
- `m_axis_valid`, out, 1: result beat valid.
- `m_axis_last`, out, 1: final result beat of tile.
- `buff_is_full`, in, 1: operand buffer full.
- `buff_is_empty`, in, 1: operand buffer empty.
- `buff_rst_n`, out, 1: buffer synchronous clear, active-low.
- `buff_wr`, out, 1: buffer write strobe.
- `buff_rd`, out, 1: buffer read strobe.
- `arr_C_valid`, in, 1: array result ready.
- `arr_rst_n`, out, 1: array clear, active-low.
- `arr_en`, out, 1: array step enable.
- `arr_out_sel`, out, $clog2(OUT_BEATS) (min 1): result row select.
- `i_err_clr`, in, 1: clears `o_err`.
- `o_err`, out, 1: sticky framing/timeout error.
- `o_busy`, out, 1: high in every state except IDLE.
- `o_tile_cnt`, out, TILE_W: completed tiles, wraps modulo 2^TILE_W.

## Operation
- States: IDLE, FILL, FEED, DRAIN, OUT. State and all counters are registered; strobes are decoded combinationally from state and counters.
- Input handshake:
  - `s_axis_ready` = (IDLE or FILL) and !`buff_is_full`.
  - `buff_wr` = `s_axis_valid` & `s_axis_ready`.
  - `fill_cnt` counts accepted beats.
- IDLE:
  - `arr_rst_n`=0.
  - First accepted beat goes to FILL with `fill_cnt`=1.
  - If FILL_DEPTH=1, that beat goes directly to FEED.
- FILL:
  - Beat accepted with `s_axis_last`=1 and `fill_cnt`+1 < FILL_DEPTH (early last): `o_err`←1, `buff_rst_n`=0 that cycle, go to IDLE, `fill_cnt`←0.
  - Beat FILL_DEPTH accepted: go to FEED. If `s_axis_last`=0 on that beat, set `o_err` and still proceed.
- FEED:
  - `arr_en`=1.
  - `buff_rd`=!`buff_is_empty`.
  - When `buff_is_empty`=1, go to DRAIN and clear `drain_cnt`.
- DRAIN:
  - `arr_en`=1; `drain_cnt` increments every cycle.
  - `arr_C_valid`=1: go to OUT with `out_cnt`=0.
  - `drain_cnt`=DRAIN_CYC-1 with no `arr_C_valid` (timeout): set `o_err`, pulse `arr_rst_n`=0 and `buff_rst_n`=0, go to IDLE. The tile is not counted.
- OUT:
  - `m_axis_valid`=1; `arr_out_sel`=`out_cnt`.
  - `m_axis_last`=(`out_cnt`=OUT_BEATS-1).
  - Each handshake increments `out_cnt`.
  - Last handshake: `buff_rst_n`=0 and `arr_rst_n`=0 for that cycle, `o_tile_cnt`++, go to IDLE.
- `o_err`:
  - Set has priority over `i_err_clr` in the same cycle.
  - `o_err` does not stall the FSM.

## Timing
- Reset (asynchronous, any state) puts the block in IDLE with `fill_cnt`, `drain_cnt`, `out_cnt`, `o_tile_cnt` and `o_err` all 0.
- Output values in reset and in IDLE:
  - `m_axis_valid`=0, `m_axis_last`=0, `buff_wr`=0, `buff_rd`=0, `arr_en`=0.
  - `arr_rst_n`=0, `buff_rst_n`=1, `arr_out_sel`=0, `o_busy`=0.
  - `s_axis_ready`=!`buff_is_full`.
- Reset mid-tile abandons the tile with no output beat. The buffer contents are not guaranteed; the next tile starts with a `buff_rst_n` pulse only through the normal paths.
- Latency and flow control:
  - FILL→FEED transition: 1 cycle after the final write.
  - First `m_axis_valid`: the cycle after `arr_C_valid` is sampled in DRAIN.
  - `m_axis_valid` and `m_axis_last` stay stable while `m_axis_ready`=0.
  - `s_axis_ready` is low in FEED, DRAIN and OUT. Back-to-back tiles are possible one cycle after the last output handshake.
- `buff_is_full` with `s_axis_valid`=1 in FILL: no write, stay in FILL.

## Structure
- Package `systolic_pkg` holds:
  - typedef enum logic [2:0] `ctrl_state_t` {IDLE, FILL, FEED, DRAIN, OUT};
  - function `clog2_min1`.
- Flat single module, no sub-modules.
- Counters are sized as:
  - `fill_cnt`: $clog2(FILL_DEPTH+1);
  - `drain_cnt`: $clog2(DRAIN_CYC+1);
  - `out_cnt`: `clog2_min1`(OUT_BEATS).

## Test plan
All scenarios use DIM=4, FILL_DEPTH=8, OUT_BEATS=4, DRAIN_CYC=10.
- Normal tile:
  - Stimulus: 8 beats, last on beat 8; array model asserts `arr_C_valid` 3 cycles after empty; `m_axis_ready`=1.
  - Response: 8 `buff_wr` pulses, 8 `buff_rd` pulses, 4 output beats with `arr_out_sel` 0..3, `m_axis_last` on beat 4, `o_tile_cnt`=1, `o_err`=0.
- Early last:
  - Stimulus: last on beat 5.
  - Response: `o_err`=1, one `buff_rst_n` low cycle, back to IDLE, no `m_axis_valid`.
- Drain timeout:
  - Stimulus: `arr_C_valid` never asserted.
  - Response: exactly 10 DRAIN cycles, then `o_err`=1, IDLE, `o_tile_cnt` unchanged.
- Output backpressure:
  - Stimulus: `m_axis_ready` toggles 1,0,0,1,...
  - Response: `arr_out_sel` and `m_axis_last` hold while not ready; exactly 4 handshakes.
- Reset in OUT:
  - Stimulus: assert `i_rst_n`=0 after 2 output beats.
  - Response: all outputs at reset values immediately (asynchronously); next tile completes normally with `o_tile_cnt`=1.
- Error clear and wrap:
  - Stimulus: `i_err_clr` pulsed alone, then `i_err_clr` in the same cycle as an error set; TILE_W=2 with 5 tiles.
  - Response: `o_err` clears when pulsed alone; `o_err` stays 1 on the simultaneous set; `o_tile_cnt`=1 after 5 tiles.
